udp_sample_depacketizer: RTL and testbench

Receive-side counterpart of the Ethernet sample streamer. Accepts a byte-wide Ethernet frame stream from the MAC, checks the Ethernet, IPv4 and UDP headers against the local addresses, and strips the 42-byte header. The UDP payload is packed into `DATA_WIDTH`-bit sample words and presented on a valid/ready interface toward the JESD204 transmit transport layer.

---
 rtl/udp_depkt_pkg.sv | 29 ++
 rtl/udp_depkt_packer.sv | 93 +++++++++
 rtl/udp_sample_depacketizer.sv | 210 +++++++++++++++++++++
 tb/tb_udp_sample_depacketizer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_depkt_pkg.sv
// Shared types and header constants for the UDP sample depacketizer.
// Holds the parser state enum, protocol constants and the byte offsets
// of the checked header fields inside the 42-byte Ethernet/IPv4/UDP header.
package udp_depkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } depkt_state_t;

    localparam int unsigned HDR_LEN   = 42;
    localparam int unsigned HDR_IDX_W = 6;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

    localparam int unsigned OFF_DMAC    = 0;
    localparam int unsigned OFF_ETYPE   = 12;
    localparam int unsigned OFF_VER_IHL = 14;
    localparam int unsigned OFF_PROTO   = 23;
    localparam int unsigned OFF_DIP     = 30;
    localparam int unsigned OFF_DPORT   = 36;
    localparam int unsigned OFF_ULEN    = 38;

endpackage

// File: rtl/udp_depkt_packer.sv
// Byte-to-word packer with a single output register.
// Ports: byte_data/byte_valid/byte_write/word_last come from the parser,
// byte_ready_c is the combinational accept back to the byte source,
// sof_arm marks the next emitted word as start-of-packet,
// sample_* is the registered valid/ready word output.
module udp_depkt_packer
#(
    parameter int unsigned DATA_WIDTH = 96
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sof_arm,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    input  logic                  byte_write,
    input  logic                  word_last,
    output logic                  byte_ready_c,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sample_sof,
    output logic                  sample_last
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0]      byte_idx;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_c;
    logic                  sof_pending;
    logic                  word_end_c;
    logic                  stall_c;
    logic                  fire_c;
    logic                  push_c;

    // A word closes on a full lane set or on the final/truncating byte.
    assign word_end_c   = word_last || (byte_idx == IDX_W'(BPW - 1));
    // Only a word-closing byte must wait for the output register to free up.
    assign stall_c      = byte_write && word_end_c && sample_valid && !sample_ready;
    assign byte_ready_c = !stall_c;
    assign fire_c       = byte_write && byte_valid && !stall_c;
    assign push_c       = fire_c && word_end_c;

    // Accumulator with the current byte merged into its lane.
    always_comb begin : lane_merge
        acc_c = acc;
        for (int unsigned i = 0; i < BPW; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                acc_c[8*i +: 8] = byte_data;
            end
        end
    end

    // Accumulator, lane index, sof tracking and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            byte_idx     <= '0;
            sof_pending  <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_sof   <= 1'b0;
            sample_last  <= 1'b0;
        end else begin
            if (fire_c) begin
                if (push_c) begin
                    acc      <= '0;
                    byte_idx <= '0;
                end else begin
                    acc      <= acc_c;
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end

            if (sof_arm) begin
                sof_pending <= 1'b1;
            end else if (push_c) begin
                sof_pending <= 1'b0;
            end

            if (push_c) begin
                sample_valid <= 1'b1;
                sample_data  <= acc_c;
                sample_sof   <= sof_pending;
                sample_last  <= word_last;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udp_sample_depacketizer.sv
// UDP sample depacketizer: parses Ethernet/IPv4/UDP headers against the
// local MAC/IP/port, strips the 42-byte header and packs the UDP payload
// into DATA_WIDTH-bit words.
// Ports: eth_rx_* byte stream in (valid/ready/last), sample_* word stream
// out (valid/ready, sof/last), packets_received/packets_dropped/
// bytes_received statistics.
// Build option: define UDP_DEPKT_STATS_EN to implement the statistics
// counters; otherwise they read as zero.
module udp_sample_depacketizer
    import udp_depkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 96,
    parameter logic [47:0] LOCAL_MAC  = 48'hAABBCCDDEEFF,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80101,
    parameter logic [15:0] LOCAL_PORT = 16'h1234
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            eth_rx_data,
    input  logic                  eth_rx_valid,
    input  logic                  eth_rx_last,
    output logic                  eth_rx_ready,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sample_sof,
    output logic                  sample_last,
    output logic [31:0]           packets_received,
    output logic [31:0]           packets_dropped,
    output logic [31:0]           bytes_received
);

    localparam logic [HDR_IDX_W-1:0] LAST_HDR_IDX = HDR_IDX_W'(HDR_LEN - 1);

    depkt_state_t         state;
    depkt_state_t         state_next;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic [HDR_IDX_W-1:0] cur_idx_c;
    logic [15:0]          udp_len;
    logic [15:0]          remain;
    logic                 accept_c;
    logic                 hdr_ok_c;
    logic                 byte_write_c;
    logic                 byte_fire_c;
    logic                 word_last_c;
    logic                 pkt_ok_c;
    logic                 pkt_drop_c;
    logic                 sof_arm_c;
    logic                 load_remain_c;

    assign accept_c     = eth_rx_valid && eth_rx_ready;
    // The byte accepted in IDLE is header byte 0.
    assign cur_idx_c    = (state == IDLE) ? '0 : hdr_idx;
    assign byte_write_c = (state == PAYLOAD) && (remain != 16'd0);
    assign byte_fire_c  = accept_c && byte_write_c;
    // Last payload byte, or a truncating last byte, closes the word as final.
    assign word_last_c  = (remain == 16'd1) || eth_rx_last;

    // Per-byte header field compare.
    always_comb begin : hdr_compare
        hdr_ok_c = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (cur_idx_c == HDR_IDX_W'(OFF_DMAC + i) && eth_rx_data != LOCAL_MAC[8*(5-i) +: 8])
                hdr_ok_c = 1'b0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (cur_idx_c == HDR_IDX_W'(OFF_DIP + i) && eth_rx_data != LOCAL_IP[8*(3-i) +: 8])
                hdr_ok_c = 1'b0;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            if (cur_idx_c == HDR_IDX_W'(OFF_DPORT + i) && eth_rx_data != LOCAL_PORT[8*(1-i) +: 8])
                hdr_ok_c = 1'b0;
            if (cur_idx_c == HDR_IDX_W'(OFF_ETYPE + i) && eth_rx_data != ETHERTYPE_IPV4[8*(1-i) +: 8])
                hdr_ok_c = 1'b0;
        end
        if (cur_idx_c == HDR_IDX_W'(OFF_VER_IHL) && eth_rx_data != IPV4_VER_IHL)
            hdr_ok_c = 1'b0;
        if (cur_idx_c == HDR_IDX_W'(OFF_PROTO) && eth_rx_data != IP_PROTO_UDP)
            hdr_ok_c = 1'b0;
        if (cur_idx_c == HDR_IDX_W'(OFF_ULEN + 1) && {udp_len[15:8], eth_rx_data} < UDP_HDR_LEN)
            hdr_ok_c = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin : next_state
        state_next = state;
        case (state)
            IDLE, HEADER: begin
                if (accept_c) begin
                    if (!hdr_ok_c)                   state_next = eth_rx_last ? IDLE : DROP;
                    else if (eth_rx_last)            state_next = IDLE;
                    else if (cur_idx_c == LAST_HDR_IDX) state_next = PAYLOAD;
                    else                             state_next = HEADER;
                end
            end
            PAYLOAD, DROP: begin
                if (accept_c && eth_rx_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin : ctrl_out
        pkt_ok_c      = 1'b0;
        pkt_drop_c    = 1'b0;
        sof_arm_c     = 1'b0;
        load_remain_c = 1'b0;
        case (state)
            IDLE, HEADER: begin
                if (accept_c) begin
                    if (eth_rx_last) begin
                        // Only a clean byte 41 with an empty payload completes here.
                        if (hdr_ok_c && cur_idx_c == LAST_HDR_IDX && udp_len == UDP_HDR_LEN)
                            pkt_ok_c = 1'b1;
                        else
                            pkt_drop_c = 1'b1;
                    end else if (hdr_ok_c && cur_idx_c == LAST_HDR_IDX) begin
                        sof_arm_c     = 1'b1;
                        load_remain_c = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept_c && eth_rx_last) begin
                    if (remain <= 16'd1) pkt_ok_c   = 1'b1;
                    else                 pkt_drop_c = 1'b1;
                end
            end
            DROP: begin
                if (accept_c && eth_rx_last) pkt_drop_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Header index, UDP length latch and payload byte budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx <= '0;
            udp_len <= '0;
            remain  <= '0;
        end else begin
            if (accept_c) begin
                if (state_next == HEADER) hdr_idx <= cur_idx_c + HDR_IDX_W'(1);
                else                      hdr_idx <= '0;
                if (state == HEADER && cur_idx_c == HDR_IDX_W'(OFF_ULEN))
                    udp_len[15:8] <= eth_rx_data;
                if (state == HEADER && cur_idx_c == HDR_IDX_W'(OFF_ULEN + 1))
                    udp_len[7:0] <= eth_rx_data;
            end
            if (load_remain_c)    remain <= udp_len - UDP_HDR_LEN;
            else if (byte_fire_c) remain <= remain - 16'd1;
        end
    end

    udp_depkt_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .sof_arm      (sof_arm_c),
        .byte_data    (eth_rx_data),
        .byte_valid   (eth_rx_valid),
        .byte_write   (byte_write_c),
        .word_last    (word_last_c),
        .byte_ready_c (eth_rx_ready),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_sof   (sample_sof),
        .sample_last  (sample_last)
    );

`ifdef UDP_DEPKT_STATS_EN
    logic [31:0] rx_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] byte_cnt;

    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= '0;
            drop_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            if (pkt_ok_c)    rx_cnt   <= rx_cnt + 32'd1;
            if (pkt_drop_c)  drop_cnt <= drop_cnt + 32'd1;
            if (byte_fire_c) byte_cnt <= byte_cnt + 32'd1;
        end
    end

    assign packets_received = rx_cnt;
    assign packets_dropped  = drop_cnt;
    assign bytes_received   = byte_cnt;
`else
    logic unused_stats;
    assign unused_stats     = ^{pkt_ok_c, pkt_drop_c};
    assign packets_received = 32'd0;
    assign packets_dropped  = 32'd0;
    assign bytes_received   = 32'd0;
`endif

endmodule

// File: tb/tb_udp_sample_depacketizer.sv
// Scoreboard bench for udp_sample_depacketizer: directed frames push their
// expected words into a queue, a negedge monitor pops and compares.
module tb_udp_sample_depacketizer;

    localparam int unsigned DW = 96;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    eth_rx_data = '0;
    logic          eth_rx_valid = 1'b0;
    logic          eth_rx_last = 1'b0;
    logic          eth_rx_ready;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready = 1'b1;
    logic          sample_sof;
    logic          sample_last;
    logic [31:0]   packets_received;
    logic [31:0]   packets_dropped;
    logic [31:0]   bytes_received;

    int          checks = 0;
    int          failures = 0;
    int          words_seen = 0;
    bit          rx_ready_low_seen = 1'b0;
    bit          stall_prev = 1'b0;
    word_t       prev_word;
    word_t       exp_q[$];
    logic [7:0]  frame[$];

    udp_sample_depacketizer dut (
        .clk              (clk),
        .reset            (reset),
        .eth_rx_data      (eth_rx_data),
        .eth_rx_valid     (eth_rx_valid),
        .eth_rx_last      (eth_rx_last),
        .eth_rx_ready     (eth_rx_ready),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .sample_sof       (sample_sof),
        .sample_last      (sample_last),
        .packets_received (packets_received),
        .packets_dropped  (packets_dropped),
        .bytes_received   (bytes_received)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ec(input logic [31:0] v);
`ifdef UDP_DEPKT_STATS_EN
        return v;
`else
        return (v == 32'd0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic word_t mk(input logic [DW-1:0] d, input logic s, input logic l);
        word_t w;
        w.data = d;
        w.sof  = s;
        w.last = l;
        return w;
    endfunction

    // Output monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (!eth_rx_ready) rx_ready_low_seen = 1'b1;
            if (stall_prev && sample_valid)
                check("hold_stable", 128'({sample_data, sample_sof, sample_last}), 128'(prev_word));
            if (sample_valid && sample_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 128'({sample_data, sample_sof, sample_last}), 128'(0));
                end else begin
                    check("word", 128'({sample_data, sample_sof, sample_last}), 128'(exp_q.pop_front()));
                end
            end
            stall_prev = sample_valid && !sample_ready;
            prev_word  = mk(sample_data, sample_sof, sample_last);
        end
    end

    task automatic build_frame(input logic [15:0] dport, input logic [15:0] ulen,
                               input int npay, input int npad);
        logic [47:0] dmac = 48'hAABBCCDDEEFF;
        logic [31:0] dip  = 32'hC0A80101;
        logic [15:0] tlen = ulen + 16'd20;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dmac[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'(i + 2));
        frame.push_back(8'h08); frame.push_back(8'h00);
        frame.push_back(8'h45); frame.push_back(8'h00);
        frame.push_back(tlen[15:8]); frame.push_back(tlen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'h40); frame.push_back(8'h00);
        frame.push_back(8'h40); frame.push_back(8'h11);
        frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'hC0); frame.push_back(8'hA8);
        frame.push_back(8'h01); frame.push_back(8'h02);
        for (int i = 0; i < 4; i++) frame.push_back(dip[8*(3-i) +: 8]);
        frame.push_back(8'h40); frame.push_back(8'h00);
        frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
        frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        for (int i = 0; i < npay; i++) frame.push_back(8'(i));
        for (int i = 0; i < npad; i++) frame.push_back(8'hEE);
    endtask

    // Sends the first n bytes of frame; entered and left at posedge+1.
    task automatic send_bytes(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            int waits = 0;
            eth_rx_data  = frame[i];
            eth_rx_valid = 1'b1;
            eth_rx_last  = use_last && (i == frame.size() - 1);
            while (!acc) begin
                @(negedge clk);
                acc = eth_rx_ready;
                @(posedge clk); #1;
                waits++;
                if (!acc && waits > 200) begin
                    check("rx_accept_timeout", 128'(0), 128'(1));
                    i = n;
                    acc = 1'b1;
                end
            end
        end
        eth_rx_valid = 1'b0;
        eth_rx_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name, input logic [31:0] rx,
                                  input logic [31:0] dr, input logic [31:0] by);
        check({name, "_rx"}, 128'(packets_received), 128'(ec(rx)));
        check({name, "_drop"}, 128'(packets_dropped), 128'(ec(dr)));
        check({name, "_bytes"}, 128'(bytes_received), 128'(ec(by)));
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        check({name, "_valid"}, 128'(sample_valid), 128'(0));
        check({name, "_word"}, 128'({sample_data, sample_sof, sample_last}), 128'(0));
        check({name, "_ready"}, 128'(eth_rx_ready), 128'(1));
        check_counters(name, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [DW-1:0] W0_24 = 96'h0B0A09080706050403020100;
    localparam logic [DW-1:0] W1_24 = 96'h17161514131211100F0E0D0C;
    localparam logic [DW-1:0] W1_18 = 96'h00000000000011100F0E0D0C;

    initial begin
        int n;
        int seen0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // Valid frame, 24 payload bytes, no backpressure.
        build_frame(16'h1234, 16'd32, 24, 0);
        exp_q.push_back(mk(W0_24, 1'b1, 1'b0));
        exp_q.push_back(mk(W1_24, 1'b0, 1'b1));
        send_bytes(frame.size(), 1'b1);
        drain("t1_drain");
        check_counters("t1", 32'd1, 32'd0, 32'd24);
        check("t1_no_backpressure", 128'(rx_ready_low_seen), 128'(0));

        // Wrong destination port is dropped with no output.
        seen0 = words_seen;
        build_frame(16'h1235, 16'd32, 24, 0);
        send_bytes(frame.size(), 1'b1);
        drain("t2_drain");
        check("t2_no_words", 128'(words_seen - seen0), 128'(0));
        check_counters("t2", 32'd1, 32'd1, 32'd24);

        // Short payload plus Ethernet pad.
        seen0 = words_seen;
        build_frame(16'h1234, 16'd26, 18, 6);
        exp_q.push_back(mk(W0_24, 1'b1, 1'b0));
        exp_q.push_back(mk(W1_18, 1'b0, 1'b1));
        send_bytes(frame.size(), 1'b1);
        drain("t3_drain");
        check("t3_word_count", 128'(words_seen - seen0), 128'(2));
        check_counters("t3", 32'd2, 32'd1, 32'd42);

        // Frame cut at header byte 20, then a good frame.
        build_frame(16'h1234, 16'd32, 24, 0);
        while (frame.size() > 21) void'(frame.pop_back());
        send_bytes(frame.size(), 1'b1);
        drain("t4a_drain");
        check_counters("t4a", 32'd2, 32'd2, 32'd42);
        build_frame(16'h1234, 16'd32, 24, 0);
        exp_q.push_back(mk(W0_24, 1'b1, 1'b0));
        exp_q.push_back(mk(W1_24, 1'b0, 1'b1));
        send_bytes(frame.size(), 1'b1);
        drain("t4b_drain");
        check_counters("t4b", 32'd3, 32'd2, 32'd66);

        // Downstream stall for 30 cycles once the first word is out.
        rx_ready_low_seen = 1'b0;
        build_frame(16'h1234, 16'd32, 24, 0);
        exp_q.push_back(mk(W0_24, 1'b1, 1'b0));
        exp_q.push_back(mk(W1_24, 1'b0, 1'b1));
        fork
            send_bytes(frame.size(), 1'b1);
            begin
                n = 0;
                while (!sample_valid && n < 500) begin
                    @(posedge clk); #1;
                    n++;
                end
                sample_ready = 1'b0;
                repeat (30) @(posedge clk);
                #1 sample_ready = 1'b1;
            end
        join
        drain("t5_drain");
        check("t5_rx_ready_fell", 128'(rx_ready_low_seen), 128'(1));
        check_counters("t5", 32'd4, 32'd2, 32'd90);

        // Reset at payload byte 5, then a good frame.
        build_frame(16'h1234, 16'd32, 24, 0);
        send_bytes(47, 1'b0);
        eth_rx_data  = frame[47];
        eth_rx_valid = 1'b1;
        reset        = 1'b1;
        @(posedge clk); #1;
        reset        = 1'b0;
        eth_rx_valid = 1'b0;
        check_reset_state("t6_reset");
        exp_q.push_back(mk(W0_24, 1'b1, 1'b0));
        exp_q.push_back(mk(W1_24, 1'b0, 1'b1));
        send_bytes(frame.size(), 1'b1);
        drain("t6_drain");
        check_counters("t6", 32'd1, 32'd0, 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
